vram_port_arbiter: RTL and testbench

Shares one synchronous VRAM port (VRAM32-class: 14-bit address, 32-bit data, one-cycle read latency) between the pixel renderer and a CPU/DMA requester. The renderer has absolute, zero-wait priority so scan-out timing is never disturbed. CPU accesses are latched and issued in the first cycle the renderer leaves idle. The block sits between the VRAM macro and the renderer/CPU bus, and reports worst-case CPU wait for tuning the renderer's fetch schedule.

---
 rtl/vram_port_arbiter_pkg.sv | 19 +
 rtl/vram_port_arbiter_sat_wait_counter.sv | 34 +++
 rtl/vram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_vram_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_port_arbiter_pkg.sv
// Shared types and default widths for the VRAM port arbiters.
package vram_port_arbiter_pkg;

    localparam int VRAM_ADDR_W       = 14;
    localparam int VRAM_DATA_W       = 32;
    localparam int VRAM_WAIT_W       = 12;
    localparam int VRAM_STARVE_LIMIT = 1600;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_PEND   = 2'd1,
        ARB_RDWAIT = 2'd2
    } arb_state_t;

    function automatic logic arb_busy(input arb_state_t s);
        return s != ARB_IDLE;
    endfunction

endpackage

// File: rtl/vram_port_arbiter_sat_wait_counter.sv
// Saturating CPU wait counter with a running maximum captured on each issue.
module vram_port_arbiter_sat_wait_counter #(
    parameter int WAIT_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              take,
    output logic [WAIT_W-1:0] cnt,
    output logic [WAIT_W-1:0] max_cnt
);

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (&v) ? v : v + WAIT_W'(1);
    endfunction

    function automatic logic [WAIT_W-1:0] max_of(input logic [WAIT_W-1:0] a,
                                                 input logic [WAIT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            max_cnt <= '0;
        end else if (take) begin
            max_cnt <= max_of(max_cnt, cnt);
            cnt     <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single VRAM port shared by the renderer (absolute priority) and one CPU/DMA requester.
module vram_port_arbiter
    import vram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int WAIT_W       = VRAM_WAIT_W,
    parameter int STARVE_LIMIT = VRAM_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gpu_req,
    input  logic [ADDR_W-1:0] gpu_addr,
    output logic [DATA_W-1:0] gpu_q,
    input  logic              cpu_start,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic [WAIT_W-1:0] max_wait,
    output logic              starve,
    input  logic              starve_clr
);

    localparam logic [WAIT_W-1:0] STARVE_AT = WAIT_W'(STARVE_LIMIT - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              req_we_p0;
    logic [ADDR_W-1:0] req_addr_p0;
    logic [DATA_W-1:0] req_wdata_p0;
    logic              accept;
    logic              issue;
    logic              waiting;
    logic              done_next;
    logic [WAIT_W-1:0] wait_cnt;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        waiting    = 1'b0;
        done_next  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (cpu_start) begin
                    accept     = 1'b1;
                    state_next = ARB_PEND;
                end
            end
            ARB_PEND: begin
                if (gpu_req) begin
                    waiting = 1'b1;
                end else begin
                    issue = 1'b1;
                    if (req_we_p0) begin
                        done_next  = 1'b1;
                        state_next = ARB_IDLE;
                    end else begin
                        state_next = ARB_RDWAIT;
                    end
                end
            end
            ARB_RDWAIT: begin
                done_next  = 1'b1;
                state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // p0: request latched at the strobe; p1: read data returned from the macro
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            req_we_p0    <= 1'b0;
            req_addr_p0  <= '0;
            req_wdata_p0 <= '0;
            cpu_done     <= 1'b0;
            cpu_rdata    <= '0;
            starve       <= 1'b0;
        end else begin
            state    <= state_next;
            cpu_done <= done_next;
            if (accept) begin
                req_we_p0    <= cpu_we;
                req_addr_p0  <= cpu_addr;
                req_wdata_p0 <= cpu_wdata;
            end
            if (state == ARB_RDWAIT) begin
                cpu_rdata <= mem_q;
            end
            if (waiting && wait_cnt == STARVE_AT) begin
                starve <= 1'b1;
            end else if (starve_clr) begin
                starve <= 1'b0;
            end
        end
    end

    vram_port_arbiter_sat_wait_counter #(
        .WAIT_W (WAIT_W)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .inc     (waiting),
        .take    (issue),
        .cnt     (wait_cnt),
        .max_cnt (max_wait)
    );

    // Reset gates the write strobe because the state register still holds its old value then.
    always_comb begin
        mem_addr = gpu_req ? gpu_addr : req_addr_p0;
        mem_we   = issue && req_we_p0 && !reset;
    end

    assign mem_d    = req_wdata_p0;
    assign gpu_q    = mem_q;
    assign cpu_busy = arb_busy(state);

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: VRAM model, transaction-level reference, directed scenarios.
module tb_vram_port_arbiter;

    localparam int STARVE_LIMIT = 1600;
    localparam int WAIT_MAX     = 4095;

    logic        clk = 1'b0;
    logic        reset;
    logic        gpu_req;
    logic [13:0] gpu_addr;
    logic [31:0] gpu_q;
    logic        cpu_start;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_busy;
    logic [13:0] mem_addr;
    logic [31:0] mem_d;
    logic        mem_we;
    logic [31:0] mem_q;
    logic [11:0] max_wait;
    logic        starve;
    logic        starve_clr;

    vram_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .gpu_req    (gpu_req),
        .gpu_addr   (gpu_addr),
        .gpu_q      (gpu_q),
        .cpu_start  (cpu_start),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .cpu_busy   (cpu_busy),
        .mem_addr   (mem_addr),
        .mem_d      (mem_d),
        .mem_we     (mem_we),
        .mem_q      (mem_q),
        .max_wait   (max_wait),
        .starve     (starve),
        .starve_clr (starve_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // VRAM macro: synchronous, one-cycle read latency
    logic [31:0] vram [0:16383];
    logic [31:0] mem_q_r = '0;
    assign mem_q = mem_q_r;
    always @(posedge clk) begin
        mem_q_r <= vram[mem_addr];
        if (mem_we) vram[mem_addr] <= mem_d;
    end

    // Reference: one outstanding CPU transaction, issued on the first renderer-free cycle
    logic [31:0] mm [0:16383];
    bit          model_ok = 1'b0;
    bit          m_pend, m_rd, m_we, e_done, e_starve, gq_valid, set_st;
    logic [13:0] m_addr, exp_addr;
    logic [31:0] m_wdata, m_rd_data, e_rdata, gq_exp;
    int          m_wait, e_max;

    always @(posedge clk) begin
        gq_valid = gpu_req;
        gq_exp   = mm[gpu_addr];
        if (reset) begin
            model_ok = 1'b1;
            m_pend   = 1'b0;
            m_rd     = 1'b0;
            m_we     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
            e_done   = 1'b0;
            e_rdata  = '0;
            e_starve = 1'b0;
            m_wait   = 0;
            e_max    = 0;
        end else if (model_ok) begin
            set_st = 1'b0;
            e_done = 1'b0;
            if (m_rd) begin
                e_rdata = m_rd_data;
                e_done  = 1'b1;
                m_rd    = 1'b0;
            end else if (m_pend) begin
                if (gpu_req) begin
                    if (m_wait < WAIT_MAX) m_wait++;
                    if (m_wait == STARVE_LIMIT) set_st = 1'b1;
                end else begin
                    if (m_wait > e_max) e_max = m_wait;
                    m_wait = 0;
                    m_pend = 1'b0;
                    if (m_we) begin
                        mm[m_addr] = m_wdata;
                        e_done     = 1'b1;
                    end else begin
                        m_rd      = 1'b1;
                        m_rd_data = mm[m_addr];
                    end
                end
            end else if (cpu_start) begin
                m_pend  = 1'b1;
                m_we    = cpu_we;
                m_addr  = cpu_addr;
                m_wdata = cpu_wdata;
            end
            if (set_st) e_starve = 1'b1;
            else if (starve_clr) e_starve = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            exp_addr = gpu_req ? gpu_addr : m_addr;
            chk("busy",     64'(cpu_busy),  64'(m_pend || m_rd));
            chk("done",     64'(cpu_done),  64'(e_done));
            chk("rdata",    64'(cpu_rdata), 64'(e_rdata));
            chk("max_wait", 64'(max_wait),  64'(e_max));
            chk("starve",   64'(starve),    64'(e_starve));
            chk("mem_addr", 64'(mem_addr),  64'(exp_addr));
            chk("mem_we",   64'(mem_we),    64'(!reset && !gpu_req && m_pend && m_we));
            chk("mem_d",    64'(mem_d),     64'(m_wdata));
            if (gq_valid) chk("gpu_q", 64'(gpu_q), 64'(gq_exp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int we_n, mis_n, dn_n;

    initial begin
        for (int i = 0; i < 16384; i++) begin
            vram[i] = 32'hA500_0000 ^ 32'(i);
            mm[i]   = 32'hA500_0000 ^ 32'(i);
        end
        vram[14'h0123] = 32'hDEAD_BEEF;
        mm[14'h0123]   = 32'hDEAD_BEEF;
        reset = 1'b1; gpu_req = 1'b0; gpu_addr = '0; cpu_start = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; starve_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",  64'(cpu_busy),  64'd0);
        chk("rst_done",  64'(cpu_done),  64'd0);
        chk("rst_rdata", 64'(cpu_rdata), 64'd0);
        chk("rst_max",   64'(max_wait),  64'd0);
        chk("rst_we",    64'(mem_we),    64'd0);
        step();

        // Uncontended read
        cpu_start = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
        step();
        cpu_start = 1'b0;
        @(negedge clk);
        chk("t1_issue_addr", 64'(mem_addr), 64'h0123);
        chk("t1_busy",       64'(cpu_busy), 64'd1);
        step();
        @(negedge clk);
        chk("t1_done_c2", 64'(cpu_done), 64'd0);
        step();
        @(negedge clk);
        chk("t1_done_c3", 64'(cpu_done),  64'd1);
        chk("t1_rdata",   64'(cpu_rdata), 64'hDEAD_BEEF);
        chk("t1_max",     64'(max_wait),  64'd0);
        step();
        @(negedge clk);
        chk("t1_done_c4", 64'(cpu_done), 64'd0);
        step();

        // Write held off by 10 renderer cycles
        cpu_start = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0200; cpu_wdata = 32'h55AA_55AA;
        step();
        cpu_start = 1'b0; gpu_req = 1'b1; we_n = 0;
        for (int i = 0; i < 10; i++) begin
            gpu_addr = 14'(14'h1000 + i);
            @(negedge clk);
            if (mem_we) we_n++;
            step();
        end
        gpu_req = 1'b0;
        @(negedge clk);
        chk("t2_we_contended", 64'(we_n),     64'd0);
        chk("t2_we_issue",     64'(mem_we),   64'd1);
        chk("t2_issue_addr",   64'(mem_addr), 64'h0200);
        step();
        @(negedge clk);
        chk("t2_done", 64'(cpu_done),       64'd1);
        chk("t2_max",  64'(max_wait),       64'd10);
        chk("t2_mem",  64'(vram[14'h0200]), 64'h55AA_55AA);
        step();

        // Renderer owns the port for 640 cycles while the CPU keeps offering a write
        gpu_req = 1'b1; cpu_start = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0300;
        cpu_wdata = 32'h0BAD_F00D; we_n = 0; mis_n = 0; dn_n = 0;
        for (int i = 0; i < 640; i++) begin
            gpu_addr = 14'(i);
            @(negedge clk);
            if (mem_we) we_n++;
            if (mem_addr != gpu_addr) mis_n++;
            if (cpu_done) dn_n++;
            step();
        end
        cpu_start = 1'b0; gpu_req = 1'b0;
        chk("t3_we_count",   64'(we_n),  64'd0);
        chk("t3_addr_miss",  64'(mis_n), 64'd0);
        chk("t3_cpu_issues", 64'(dn_n),  64'd0);
        @(negedge clk);
        chk("t3_release_we", 64'(mem_we), 64'd1);
        step();
        @(negedge clk);
        chk("t3_done", 64'(cpu_done), 64'd1);
        chk("t3_max",  64'(max_wait), 64'd639);
        step();

        // Starvation of a pending read, then set-vs-clear priority
        cpu_start = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
        step();
        cpu_start = 1'b0; gpu_req = 1'b1;
        for (int k = 1; k < STARVE_LIMIT; k++) begin
            gpu_addr = 14'(k * 7);
            step();
        end
        starve_clr = 1'b1;
        @(negedge clk);
        chk("t4_starve_pre", 64'(starve), 64'd0);
        step();
        @(negedge clk);
        chk("t4_set_wins", 64'(starve), 64'd1);
        step();
        @(negedge clk);
        chk("t4_clr", 64'(starve), 64'd0);
        starve_clr = 1'b0;
        step();
        gpu_req = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("t4_done",  64'(cpu_done),  64'd1);
        chk("t4_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
        chk("t4_max",   64'(max_wait),  64'd1602);
        step();

        // Ignored start while busy, then a start coincident with done
        cpu_start = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0400; cpu_wdata = 32'h1234_5678;
        step();
        gpu_req = 1'b1; cpu_addr = 14'h0500; cpu_wdata = 32'h0000_0BAD;
        @(negedge clk);
        chk("t5_busy", 64'(cpu_busy), 64'd1);
        step();
        cpu_start = 1'b0; gpu_req = 1'b0;
        @(negedge clk);
        chk("t5_issue_addr", 64'(mem_addr), 64'h0400);
        chk("t5_issue_d",    64'(mem_d),    64'h1234_5678);
        step();
        cpu_start = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0400;
        @(negedge clk);
        chk("t5_done_w", 64'(cpu_done), 64'd1);
        step();
        cpu_start = 1'b0;
        @(negedge clk);
        chk("t5_b2b_busy", 64'(cpu_busy), 64'd1);
        chk("t5_b2b_addr", 64'(mem_addr), 64'h0400);
        step();
        step();
        @(negedge clk);
        chk("t5_done_r",  64'(cpu_done),       64'd1);
        chk("t5_rdata",   64'(cpu_rdata),      64'h1234_5678);
        chk("t5_ignored", 64'(vram[14'h0500]), 64'hA500_0500);
        step();

        // Reset while the read is in RDWAIT
        cpu_start = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
        step();
        cpu_start = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_we_in_reset", 64'(mem_we), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_done",  64'(cpu_done),  64'd0);
        chk("t6_busy",  64'(cpu_busy),  64'd0);
        chk("t6_rdata", 64'(cpu_rdata), 64'd0);
        chk("t6_max",   64'(max_wait),  64'd0);
        chk("t6_addr",  64'(mem_addr),  64'd0);
        step();
        cpu_start = 1'b1; cpu_addr = 14'h0011;
        step();
        cpu_start = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("t6_after_done",  64'(cpu_done),  64'd1);
        chk("t6_after_rdata", 64'(cpu_rdata), 64'hA500_0011);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
